// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type encoding, fetch FSM states and the
// branch-condition helper used by the next-PC logic.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BEQ     = 3'd1,
        BNE     = 3'd2,
        BLT     = 3'd3,
        BGT     = 3'd4,
        BLE     = 3'd5,
        BGE     = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } fetch_state_e;

    function automatic logic branch_taken(input br_type_e br, input logic zero, input logic less);
        logic taken;
        case (br)
            BEQ:     taken = zero;
            BNE:     taken = ~zero;
            BLT:     taken = less;
            BGT:     taken = ~less & ~zero;
            BLE:     taken = less | zero;
            BGE:     taken = ~less;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC selection: branch condition evaluation followed by
// the jr > jump/jal > taken branch > sequential priority mux.
module next_pc_select
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] instr_pc,
    input  logic [PC_WIDTH-1:0] br_off,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic [2:0]          br_type,
    input  logic                zero,
    input  logic                less,
    input  logic                jump,
    input  logic                jal,
    input  logic                jr,
    input  logic [PC_WIDTH-1:0] jr_target,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic                br_taken_s;
    logic [PC_WIDTH-1:0] seq_pc_s;

    // All arithmetic wraps naturally at PC_WIDTH bits.
    always_comb begin
        br_taken_s = branch_taken(br_type_e'(br_type), zero, less);
        seq_pc_s   = instr_pc + PC_WIDTH'(1);
        if (jr) begin
            next_pc = jr_target;
        end else if (jump | jal) begin
            next_pc = jump_target;
        end else if (br_taken_s) begin
            next_pc = seq_pc_s + br_off;
        end else begin
            next_pc = seq_pc_s;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and next-PC unit: drives the synchronous ROM, waits out its
// read latency, holds a valid/stall-qualified instruction and produces the jal link.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int IMM_WIDTH   = 16,
    parameter int ROM_LATENCY = 1,
    parameter int RESET_PC    = 0,
    parameter int LINK_OFFSET = 1
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_q,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   stall,
    input  logic [2:0]             br_type,
    input  logic                   zero,
    input  logic                   less,
    input  logic                   jump,
    input  logic                   jal,
    input  logic                   jr,
    input  logic [PC_WIDTH-1:0]    jr_target,
    output logic [PC_WIDTH-1:0]    link_addr,
    output logic                   link_valid
);

    localparam int                  LAT_W      = 2;
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(ROM_LATENCY - 1);
    localparam logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] LINK_INC   = PC_WIDTH'(LINK_OFFSET);

    fetch_state_e           state_r;
    fetch_state_e           state_s;
    logic [LAT_W-1:0]       lat_cnt_r;
    logic                   issued_r;
    logic [PC_WIDTH-1:0]    pc_r;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic                   instr_valid_r;
    logic [PC_WIDTH-1:0]    instr_pc_r;
    logic [PC_WIDTH-1:0]    link_addr_r;
    logic                   link_valid_r;
    logic                   capture_s;
    logic                   advance_s;
    logic [PC_WIDTH-1:0]    br_off_s;
    logic [PC_WIDTH-1:0]    next_pc_s;

    // Branch offset: sign-extend the immediate, or truncate when it is wider than the PC.
    if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
        assign br_off_s = instr_r[PC_WIDTH-1:0];
    end else begin : g_imm_sext
        assign br_off_s = {{(PC_WIDTH-IMM_WIDTH){instr_r[IMM_WIDTH-1]}}, instr_r[IMM_WIDTH-1:0]};
    end

    next_pc_select #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc_select (
        .instr_pc    (instr_pc_r),
        .br_off      (br_off_s),
        .jump_target (instr_r[PC_WIDTH-1:0]),
        .br_type     (br_type),
        .zero        (zero),
        .less        (less),
        .jump        (jump),
        .jal         (jal),
        .jr          (jr),
        .jr_target   (jr_target),
        .next_pc     (next_pc_s)
    );

    // FSM state register.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (capture_s) begin
                    state_s = S_VALID;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_VALID: begin
                if (advance_s) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_VALID;
                end
            end
            default: state_s = S_FETCH;
        endcase
    end

    // FSM outputs; on advance the ROM already sees next_pc so its access overlaps the hand-off.
    always_comb begin
        capture_s = 1'b0;
        advance_s = 1'b0;
        rom_addr  = pc_r;
        case (state_r)
            S_FETCH: begin
                capture_s = issued_r & (lat_cnt_r == LAT_LAST);
            end
            S_VALID: begin
                advance_s = instr_valid_r & ~stall;
                if (advance_s) begin
                    rom_addr = next_pc_s;
                end else begin
                    rom_addr = pc_r;
                end
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // PC, latency counter, instruction and link registers; issued_r marks the first post-reset ROM access.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_ADDR;
            lat_cnt_r     <= {LAT_W{1'b0}};
            issued_r      <= 1'b0;
            instr_r       <= {INSTR_WIDTH{1'b0}};
            instr_valid_r <= 1'b0;
            instr_pc_r    <= {PC_WIDTH{1'b0}};
            link_addr_r   <= {PC_WIDTH{1'b0}};
            link_valid_r  <= 1'b0;
        end else begin
            issued_r     <= 1'b1;
            link_valid_r <= 1'b0;
            if (capture_s) begin
                instr_r       <= rom_q;
                instr_pc_r    <= pc_r;
                instr_valid_r <= 1'b1;
                lat_cnt_r     <= {LAT_W{1'b0}};
            end else if (advance_s) begin
                pc_r          <= next_pc_s;
                instr_valid_r <= 1'b0;
                lat_cnt_r     <= {LAT_W{1'b0}};
                if (jal) begin
                    link_addr_r  <= instr_pc_r + LINK_INC;
                    link_valid_r <= 1'b1;
                end
            end else if ((state_r == S_FETCH) && issued_r) begin
                lat_cnt_r <= lat_cnt_r + 2'd1;
            end
        end
    end

    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign instr_pc    = instr_pc_r;
    assign link_addr   = link_addr_r;
    assign link_valid  = link_valid_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a 1-cycle and a 3-cycle ROM instance, checked
// against a next-PC reference model derived from the branch/jump rules.
module tb_fetch_sequencer;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;

    logic [7:0]  rom_addr_a, instr_pc_a, link_addr_a, jr_target;
    logic [31:0] rom_q_a, instr_a;
    logic        instr_valid_a, link_valid_a;
    logic        stall = 1'b0, zero = 1'b0, less = 1'b0, jump = 1'b0, jal = 1'b0, jr = 1'b0;
    logic [2:0]  br_type = 3'd0;

    logic [7:0]  rom_addr_b, instr_pc_b, link_addr_b;
    logic [31:0] rom_q_b, instr_b;
    logic        instr_valid_b, link_valid_b;
    logic        stall_b = 1'b0, zero_b = 1'b0, less_b = 1'b0, jump_b = 1'b0, jal_b = 1'b0, jr_b = 1'b0;
    logic [2:0]  br_type_b = 3'd0;
    logic [7:0]  jr_target_b = 8'd0;

    logic [31:0] rom [256];
    logic [31:0] rom_p1_b, rom_p2_b;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_pc = 0;

    initial jr_target = 8'd0;

    fetch_sequencer #(.ROM_LATENCY(LAT_A)) dut_a (
        .MAX10_CLK1_50 (clk),          .reset       (rst_a_n),
        .rom_addr      (rom_addr_a),   .rom_q       (rom_q_a),
        .instr         (instr_a),      .instr_valid (instr_valid_a),
        .instr_pc      (instr_pc_a),   .stall       (stall),
        .br_type       (br_type),      .zero        (zero),
        .less          (less),         .jump        (jump),
        .jal           (jal),          .jr          (jr),
        .jr_target     (jr_target),    .link_addr   (link_addr_a),
        .link_valid    (link_valid_a)
    );

    fetch_sequencer #(.ROM_LATENCY(LAT_B)) dut_b (
        .MAX10_CLK1_50 (clk),          .reset       (rst_b_n),
        .rom_addr      (rom_addr_b),   .rom_q       (rom_q_b),
        .instr         (instr_b),      .instr_valid (instr_valid_b),
        .instr_pc      (instr_pc_b),   .stall       (stall_b),
        .br_type       (br_type_b),    .zero        (zero_b),
        .less          (less_b),       .jump        (jump_b),
        .jal           (jal_b),        .jr          (jr_b),
        .jr_target     (jr_target_b),  .link_addr   (link_addr_b),
        .link_valid    (link_valid_b)
    );

    // Synchronous ROM models with 1 and 3 cycles of read latency.
    always @(posedge clk) rom_q_a <= rom[rom_addr_a];
    always @(posedge clk) begin
        rom_p1_b <= rom[rom_addr_b];
        rom_p2_b <= rom_p1_b;
        rom_q_b  <= rom_p2_b;
    end

    // Reference: the address the instruction after (pc, w) should come from.
    function automatic int model_next(input int pc, input logic [31:0] w, input logic [2:0] br,
                                      input logic z, input logic l, input logic j, input logic jl,
                                      input logic r, input logic [7:0] tgt);
        bit tk;
        int off;
        case (br)
            3'd1:    tk = z;
            3'd2:    tk = !z;
            3'd3:    tk = l;
            3'd4:    tk = !l && !z;
            3'd5:    tk = l || z;
            3'd6:    tk = !l;
            default: tk = 1'b0;
        endcase
        off = int'(w[15:0]);
        if (off >= 32768) off = off - 65536;
        if (r)       return int'(tgt);
        if (j || jl) return int'(w[7:0]);
        if (tk)      return (((pc + 1 + off) % 256) + 256) % 256;
        return (pc + 1) % 256;
    endfunction

    task automatic run_advance(input int stall_cycles, input logic [2:0] b, input logic z, input logic l,
                               input logic j, input logic jl, input logic r, input logic [7:0] tgt,
                               input string tag);
        int nxt;
        int waited;
        n_cmp++;
        if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'(exp_pc) || instr_a !== rom[exp_pc]) begin
            n_bad++;
            $display("FAIL %s pre: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     tag, instr_valid_a, instr_pc_a, instr_a, 8'(exp_pc), rom[exp_pc]);
        end
        stall = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            br_type = 3'($urandom_range(0, 7));
            zero = 1'($urandom); less = 1'($urandom); jump = 1'($urandom);
            jal = 1'($urandom); jr = 1'($urandom); jr_target = 8'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'(exp_pc) || instr_a !== rom[exp_pc]
                || rom_addr_a !== 8'(exp_pc) || link_valid_a !== 1'b0) begin
                n_bad++;
                $display("FAIL %s stall%0d: valid=%b pc=%h instr=%h addr=%h lv=%b, expected 1 %h %h %h 0",
                         tag, i, instr_valid_a, instr_pc_a, instr_a, rom_addr_a, link_valid_a,
                         8'(exp_pc), rom[exp_pc], 8'(exp_pc));
            end
        end
        stall = 1'b0; br_type = b; zero = z; less = l; jump = j; jal = jl; jr = r; jr_target = tgt;
        nxt = model_next(exp_pc, rom[exp_pc], b, z, l, j, jl, r, tgt);
        @(posedge clk); #1;
        n_cmp++;
        if (instr_valid_a !== 1'b0 || link_valid_a !== jl || rom_addr_a !== 8'(nxt)) begin
            n_bad++;
            $display("FAIL %s advance: valid=%b lv=%b addr=%h, expected 0 %b %h",
                     tag, instr_valid_a, link_valid_a, rom_addr_a, jl, 8'(nxt));
        end
        if (jl) begin
            n_cmp++;
            if (link_addr_a !== 8'(exp_pc + 1)) begin
                n_bad++;
                $display("FAIL %s link_addr: got %h expected %h", tag, link_addr_a, 8'(exp_pc + 1));
            end
        end
        // Inputs while fetching must not matter.
        stall = 1'($urandom); br_type = 3'($urandom_range(0, 7)); jr = 1'($urandom);
        jump = 1'($urandom); jal = 1'b0; jr_target = 8'($urandom);
        waited = 1;
        while (instr_valid_a !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++;
        if (waited != LAT_A + 1 || instr_pc_a !== 8'(nxt) || instr_a !== rom[nxt] || link_valid_a !== 1'b0) begin
            n_bad++;
            $display("FAIL %s next: cycles=%0d pc=%h instr=%h lv=%b, expected %0d %h %h 0",
                     tag, waited, instr_pc_a, instr_a, link_valid_a, LAT_A + 1, 8'(nxt), rom[nxt]);
        end
        exp_pc = nxt;
    endtask

    task automatic test_reset();
        #2;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (instr_valid_a !== 1'b0 || rom_addr_a !== 8'h00 || instr_a !== 32'h0 || instr_pc_a !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_fetch: valid=%b addr=%h instr=%h pc=%h, expected 0 00 0 00",
                     instr_valid_a, rom_addr_a, instr_a, instr_pc_a);
        end
        n_cmp++;
        if (link_addr_a !== 8'h00 || link_valid_a !== 1'b0 || instr_valid_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_link: link=%h lv=%b valid_b=%b, expected 00 0 0",
                     link_addr_a, link_valid_a, instr_valid_b);
        end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (instr_valid_a !== ((k % 2) == 0)) begin
                n_bad++;
                $display("FAIL seq_valid c%0d: got %b expected %b", k, instr_valid_a, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                n_cmp++;
                if (instr_pc_a !== 8'(k / 2 - 1) || instr_a !== rom[k / 2 - 1]) begin
                    n_bad++;
                    $display("FAIL seq_data c%0d: pc=%h instr=%h expected %h %h",
                             k, instr_pc_a, instr_a, 8'(k / 2 - 1), rom[k / 2 - 1]);
                end
            end
        end
        exp_pc = 2;
    endtask

    task automatic test_branch();
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "jr_to_5");
        run_advance(0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "beq_taken");
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "jr_to_5b");
        run_advance(0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "beq_not_taken");
    endtask

    task automatic test_wrap();
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, "jr_to_ff");
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "seq_wrap");
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, "jr_to_fe");
        run_advance(0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "bne_wrap");
    endtask

    task automatic test_jump();
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, "jr_to_10");
        run_advance(0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "jal_over_beq");
        run_advance(0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, "jr_over_jump");
        run_advance(0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, "jal_with_jr");
    endtask

    task automatic test_stall();
        run_advance(3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "stall_beq");
        run_advance(3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "stall_seq");
        run_advance(2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "stall_jal");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_advance(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                        1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                        1'($urandom_range(0, 5) == 0), 8'($urandom), "random");
        end
    endtask

    task automatic test_reset_midcount();
        int waited;
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (instr_valid_b !== (k == 4)) begin
                n_bad++;
                $display("FAIL lat3_first c%0d: valid=%b expected %b", k, instr_valid_b, k == 4);
            end
        end
        n_cmp++;
        if (instr_pc_b !== 8'h00 || instr_b !== rom[0]) begin
            n_bad++;
            $display("FAIL lat3_data: pc=%h instr=%h expected 00 %h", instr_pc_b, instr_b, rom[0]);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_b_n = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid_b !== 1'b0 || rom_addr_b !== 8'h00 || instr_pc_b !== 8'h00 || instr_b !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset: valid=%b addr=%h pc=%h instr=%h, expected 0 00 00 0",
                     instr_valid_b, rom_addr_b, instr_pc_b, instr_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b_n = 1'b1;
        waited = 0;
        while (instr_valid_b !== 1'b1 && waited < 12) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++;
        if (waited != LAT_B + 1 || instr_pc_b !== 8'h00 || instr_b !== rom[0]) begin
            n_bad++;
            $display("FAIL restart: cycles=%0d pc=%h instr=%h, expected %0d 00 %h",
                     waited, instr_pc_b, instr_b, LAT_B + 1, rom[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'hA000_00A1;
        rom[1] = 32'hB000_00B2;
        rom[2] = 32'hC000_00C3;
        rom[5][15:0]   = 16'hFFFD;
        rom[254][15:0] = 16'h0004;
        rom[10][7:0]   = 8'h40;
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_jump();
        test_stall();
        test_random();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
